// File: rtl/row_sequencer.sv
// row_sequencer
//   Control stage ahead of the row mux. After a start pulse it walks the mux
//   Select port through rows 0..SEL_SIZE-1. Each selected row is registered and
//   offered downstream through a valid/ready handshake, tagged with its row
//   index and a last-row flag. A one-cycle done pulse follows the handshake of
//   the final row.
//
//   Every row takes one LOAD cycle (capture Mux_Out) and at least one SEND
//   cycle (offer the row until it is accepted). With row_ready held high the
//   sequencer therefore delivers one row every 2 cycles, and a full frame takes
//   2*SEL_SIZE cycles from start to done.
//
//   Optional build macro: ROW_SEQ_STALL_CNT_EN
//     defined   : stall_cnt counts SEND cycles with row_ready low. It saturates
//                 at 16'hFFFF, is cleared by reset and by an accepted start,
//                 and holds its value in IDLE so it can be read after done.
//     undefined : stall_cnt is tied to zero and no counter is built.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle frame start, honoured only in IDLE
//   abort      synchronous abort, returns to IDLE on the next edge
//   Select     registered row select to the mux
//   Mux_Out    combinational row data from the mux for the current Select
//   row_data   registered row presented downstream
//   row_idx    row number of row_data
//   row_last   high with row_valid on the final row of the frame
//   row_valid  row_data valid
//   row_ready  downstream accept (a row moves when row_valid & row_ready)
//   busy       high in any state other than IDLE
//   done       one-cycle pulse after the final row handshake
//   stall_cnt  backpressure counter (see macro above)
module row_sequencer #(
    parameter int OUT_SIZE = 532,
    parameter int SEL_SIZE = 28,
    parameter int SEL_BIT  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic [SEL_BIT-1:0]  Select,
    input  logic [OUT_SIZE-1:0] Mux_Out,
    output logic [OUT_SIZE-1:0] row_data,
    output logic [SEL_BIT-1:0]  row_idx,
    output logic                row_last,
    output logic                row_valid,
    input  logic                row_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [SEL_BIT-1:0] LAST_SEL = SEL_BIT'(SEL_SIZE - 1);

    state_t state;
    state_t state_nxt;
    logic   handshake;

    // row_valid is only ever high in SEND, so this is the accept condition.
    assign handshake = row_valid & row_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    state_nxt = SEND;
                SEND:    if (handshake) state_nxt = row_last ? IDLE : LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Select walk and downstream row register. row_last is cleared together
    // with row_valid so that it is never seen high without a valid row.
    // On abort row_data and row_idx keep their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            Select    <= '0;
            row_data  <= '0;
            row_idx   <= '0;
            row_last  <= 1'b0;
            row_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                Select    <= '0;
                row_last  <= 1'b0;
                row_valid <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        row_data  <= Mux_Out;
                        row_idx   <= Select;
                        row_last  <= (Select == LAST_SEL);
                        row_valid <= 1'b1;
                    end
                    SEND: begin
                        if (handshake) begin
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                            if (row_last) begin
                                Select <= '0;
                                done   <= 1'b1;
                            end else begin
                                Select <= Select + SEL_BIT'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ROW_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start && !abort) begin
            stall_q <= '0;
        end else if ((state == SEND) && !row_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
